// File: rtl/seq_pkg.sv
// Shared definitions for the serial front end: serializer and "101" detector
// state encodings plus the default serializer word width.
package seq_pkg;

  // Default word width of piso_serializer.
  localparam int unsigned SER_WIDTH = 8;

  // piso_serializer control states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // moore_seq_101 states, named after the suffix of the stream matched so far.
  typedef enum logic [1:0] {
    DET_S0   = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2,
    DET_S101 = 2'd3
  } det_state_e;

endpackage

// File: rtl/moore_seq_101.sv
// Moore detector for the serial pattern "101", overlapping matches allowed.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   data_in  in  serial bit, one per clock
//   data_out out high for one cycle after the final '1' of each "101"
module moore_seq_101
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  det_state_e state_q;
  det_state_e state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a '0' after a full match keeps the trailing "10" for overlap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DET_S0:   state_d = data_in ? DET_S1   : DET_S0;
      DET_S1:   state_d = data_in ? DET_S1   : DET_S10;
      DET_S10:  state_d = data_in ? DET_S101 : DET_S0;
      DET_S101: state_d = data_in ? DET_S1   : DET_S10;
      default:  state_d = DET_S0;
    endcase
  end

  // Moore output decoded from the state register only.
  assign data_out = (state_q == DET_S101);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding moore_seq_101. Accepts a WIDTH-bit word
// over valid/ready and shifts it out one bit per clock; words accepted on the
// last-bit cycle stream with no idle gap.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   load_valid  in  upstream offers load_data
//   load_ready  out word can be accepted this cycle (forced low during rst)
//   load_data   in  word to serialize, sampled on accept only
//   data_out    out current serial bit (0 when idle)
//   bit_valid   out data_out carries a word bit
//   last_bit    out current bit is the final bit of the word
module piso_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic in_shift;
  logic at_last;
  logic accept;

  // State, shift register and bit counter; reset overrides any reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from registers; only load_ready also looks at rst.
  always_comb begin
    in_shift   = (state_q == ST_SHIFT);
    at_last    = in_shift && (cnt_q == CNT_LAST);
    bit_valid  = in_shift;
    last_bit   = at_last;
    data_out   = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    load_ready = !rst && (!in_shift || at_last);
    accept     = load_valid && load_ready;
  end

  // Next-state: load on accept, shift toward the output end, return to idle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (accept) begin
          // Reload on the last bit keeps the output stream gap-free.
          shreg_d = load_data;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
